native_mem_slave: RTL and testbench

Parametrised memory slave for the picorv32 native memory interface (mem_valid/mem_ready handshake). It replaces the ad-hoc bench memory model with a reusable block that has:
- configurable RAM depth and a configurable result window
- programmable wait states
- a "tohost" completion register
- bus-error flagging and transaction counters

It sits between the CPU core and the bench, and gives every core test a single, cycle-deterministic memory.

---
 rtl/native_mem_pkg.sv | 21 ++
 rtl/native_mem_ram.sv | 24 ++
 rtl/native_mem_slave.sv | 162 ++++++++++++++++
 tb/tb_native_mem_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/native_mem_pkg.sv
// Shared types and constants for the native-interface memory slave.
// Imported by the slave top and its RAM.
package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    REG_TOHOST,
    REG_RESULT,
    REG_RAM,
    REG_UNMAPPED
  } region_t;

  localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/native_mem_ram.sv
// Single-port byte-enable main RAM, no reset.
// Read is combinational so a same-edge capture sees the pre-write word.
module native_mem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/native_mem_slave.sv
// picorv32 native-bus memory slave: RAM, result window, tohost,
// programmable wait states, bus-error flag and transaction counters.
module native_mem_slave
  import native_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] RESULT_BASE  = 32'h0000_2000,
  parameter int          RESULT_WORDS = 16,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_3FFC,
  parameter int          WAIT_CYCLES  = 0,
  parameter logic [31:0] ERR_RDATA    = ERR_RDATA_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mem_valid,
  input  logic                            mem_instr,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_wdata,
  input  logic [3:0]                      mem_wstrb,
  output logic                            mem_ready,
  output logic [31:0]                     mem_rdata,
  input  logic [$clog2(RESULT_WORDS)-1:0] res_idx,
  output logic [31:0]                     res_data,
  output logic                            done,
  output logic [31:0]                     done_code,
  output logic                            bus_err,
  output logic [31:0]                     xfer_count,
  output logic [31:0]                     fetch_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int RW = $clog2(RESULT_WORDS);

  state_t      state, state_nxt;
  region_t     reg_d, reg_q;
  logic [7:0]  wcnt;
  logic [29:0] wa, roff;
  logic        accept;
  logic        instr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [AW-1:0] ram_addr_q;
  logic [RW-1:0] ridx_q;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] res_mem [RESULT_WORDS];
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[1:0];

  assign wa   = mem_addr[31:2];
  assign roff = wa - RESULT_BASE[31:2];

  always_comb begin
    reg_d = REG_UNMAPPED;
    if (wa == TOHOST_ADDR[31:2])
      reg_d = REG_TOHOST;
    else if (roff < 30'(RESULT_WORDS))
      reg_d = REG_RESULT;
    else if (wa < 30'(DEPTH_WORDS))
      reg_d = REG_RAM;
  end

  // Ignore a request still held during the ready cycle.
  assign accept = mem_valid && !mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)
              state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (!mem_valid)
              state_nxt = IDLE;
            else if (wcnt == 8'd0)
              state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_we = (state == RESP && reg_q == REG_RAM) ? wstrb_q : 4'b0;

  native_mem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      done        <= 1'b0;
      done_code   <= '0;
      bus_err     <= 1'b0;
      xfer_count  <= '0;
      fetch_count <= '0;
      wcnt        <= '0;
      instr_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ram_addr_q  <= '0;
      ridx_q      <= '0;
      reg_q       <= REG_UNMAPPED;
      for (int i = 0; i < RESULT_WORDS; i++) res_mem[i] <= '0;
    end else begin
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          instr_q    <= mem_instr;
          wdata_q    <= mem_wdata;
          wstrb_q    <= mem_wstrb;
          ram_addr_q <= mem_addr[AW+1:2];
          ridx_q     <= roff[RW-1:0];
          reg_q      <= reg_d;
          wcnt       <= 8'(WAIT_CYCLES - 1);
        end
        WAIT: wcnt <= wcnt - 8'd1;
        RESP: begin
          mem_ready  <= 1'b1;
          xfer_count <= xfer_count + 32'd1;
          if (instr_q) fetch_count <= fetch_count + 32'd1;
          unique case (reg_q)
            REG_TOHOST: begin
              mem_rdata <= done_code;
              if (|wstrb_q) begin
                done <= 1'b1;
                if (!done) done_code <= wdata_q;
              end
            end
            REG_RESULT: begin
              mem_rdata <= res_mem[ridx_q];
              for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b])
                  res_mem[ridx_q][8*b +: 8] <= wdata_q[8*b +: 8];
              end
            end
            REG_RAM: mem_rdata <= ram_rdata;
            default: begin
              mem_rdata <= ERR_RDATA;
              bus_err   <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign res_data = res_mem[res_idx];

endmodule

// File: tb/tb_native_mem_slave.sv
// Directed bench: one slave with no wait states, one with three.
// Bus transactions are driven from a single linear initial block.
module tb_native_mem_slave;

  logic        clk;
  logic        rst [2];
  logic        v   [2];
  logic        ins [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic [3:0]  ws  [2];
  logic        rdy [2];
  logic [31:0] rd  [2];
  logic [3:0]  ridx[2];
  logic [31:0] rsd [2];
  logic        dn  [2];
  logic [31:0] dc  [2];
  logic        be  [2];
  logic [31:0] xc  [2];
  logic [31:0] fc  [2];

  int vectors;
  int miscompares;

  logic [31:0] prog [5] = '{
    32'h0010_0093, 32'h0020_0113, 32'h0020_81B3,
    32'h0000_2237, 32'h0032_2023
  };

  native_mem_slave u0 (
    .clk(clk), .reset(rst[0]), .mem_valid(v[0]), .mem_instr(ins[0]),
    .mem_addr(ad[0]), .mem_wdata(wd[0]), .mem_wstrb(ws[0]),
    .mem_ready(rdy[0]), .mem_rdata(rd[0]), .res_idx(ridx[0]),
    .res_data(rsd[0]), .done(dn[0]), .done_code(dc[0]),
    .bus_err(be[0]), .xfer_count(xc[0]), .fetch_count(fc[0])
  );

  native_mem_slave #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .reset(rst[1]), .mem_valid(v[1]), .mem_instr(ins[1]),
    .mem_addr(ad[1]), .mem_wdata(wd[1]), .mem_wstrb(ws[1]),
    .mem_ready(rdy[1]), .mem_rdata(rd[1]), .res_idx(ridx[1]),
    .res_data(rsd[1]), .done(dn[1]), .done_code(dc[1]),
    .bus_err(be[1]), .xfer_count(xc[1]), .fetch_count(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = edges after acceptance until mem_ready.
  task automatic xfer(input int s, input logic i, input logic [31:0] a,
                      input logic [31:0] w, input logic [3:0] st,
                      output logic [31:0] rdat, output int lat);
    @(negedge clk);
    v[s] = 1'b1; ins[s] = i; ad[s] = a; wd[s] = w; ws[s] = st;
    @(posedge clk);
    lat  = -1;
    rdat = 'x;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (rdy[s]) begin
        lat  = j;
        rdat = rd[s];
        break;
      end
    end
    v[s] = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      chk("ready_one_cycle", 32'(rdy[s]), 32'd0);
    end
  endtask

  task automatic run_prog(input int s, input int el, input string nm);
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      xfer(s, 1'b1, 32'(4 * i), 32'h0, 4'h0, r, lat);
      chk({nm, "_fetch"}, r, prog[i]);
      chk({nm, "_fetch_lat"}, 32'(lat), 32'(el));
    end
    xfer(s, 1'b0, 32'h0000_2000, 32'd3, 4'hF, r, lat);
    chk({nm, "_store_lat"}, 32'(lat), 32'(el));
    ridx[s] = 4'd0; #1;
    chk({nm, "_result0"}, rsd[s], 32'd3);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    logic        seen;
    vectors = 0;
    miscompares = 0;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; v[s] = 1'b0; ins[s] = 1'b0;
      ad[s] = '0; wd[s] = '0; ws[s] = '0; ridx[s] = '0;
    end
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      u0.u_ram.mem[i] = prog[i];
      u1.u_ram.mem[i] = prog[i];
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_code", dc[0], 32'd0);
    chk("rst_berr", 32'(be[0]), 32'd0);
    chk("rst_xcnt", xc[0], 32'd0);
    chk("rst_fcnt", fc[0], 32'd0);
    chk("rst_res0", rsd[0], 32'd0);

    run_prog(0, 1, "w0");
    chk("w0_xcnt", xc[0], 32'd6);
    chk("w0_fcnt", fc[0], 32'd5);

    xfer(0, 1'b0, 32'h0000_2004, 32'h1122_3344, 4'hF, r, lat);
    xfer(0, 1'b0, 32'h0000_2005, 32'hABAB_ABAB, 4'b0010, r, lat);
    chk("sb_old_rdata", r, 32'h1122_3344);
    ridx[0] = 4'd1; #1;
    chk("sb_result1", rsd[0], 32'h1122_AB44);

    chk("berr_before", 32'(be[0]), 32'd0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, r, lat);
    chk("unmapped_rdata", r, 32'hDEAD_BEEF);
    chk("unmapped_berr", 32'(be[0]), 32'd1);
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, r, lat);
    chk("lw_ram", r, 32'h0020_0113);
    chk("berr_sticky", 32'(be[0]), 32'd1);

    chk("done_before", 32'(dn[0]), 32'd0);
    xfer(0, 1'b0, 32'h0000_3FFC, 32'h0000_600D, 4'hF, r, lat);
    chk("tohost_done", 32'(dn[0]), 32'd1);
    chk("tohost_code", dc[0], 32'h0000_600D);
    xfer(0, 1'b0, 32'h0000_3FFC, 32'h0000_0BAD, 4'hF, r, lat);
    chk("tohost_code_kept", dc[0], 32'h0000_600D);
    xfer(0, 1'b0, 32'h0000_3FFC, 32'h0, 4'h0, r, lat);
    chk("tohost_rdata", r, 32'h0000_600D);
    chk("w0_xcnt_end", xc[0], 32'd13);
    chk("w0_fcnt_end", fc[0], 32'd5);

    run_prog(1, 4, "w3");
    chk("w3_xcnt", xc[1], 32'd6);
    chk("w3_fcnt", fc[1], 32'd5);

    @(negedge clk);
    v[1] = 1'b1; ins[1] = 1'b0; ad[1] = 32'h0000_2008;
    wd[1] = 32'h0000_0077; ws[1] = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[1]) seen = 1'b1;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    chk("abort_xcnt", xc[1], 32'd6);
    ridx[1] = 4'd2; #1;
    chk("abort_no_write", rsd[1], 32'd0);

    @(negedge clk);
    v[1] = 1'b1; ins[1] = 1'b0; ad[1] = 32'h0000_2008;
    wd[1] = 32'h0000_0055; ws[1] = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1; v[1] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rdy[1]) seen = 1'b1;
    end
    @(negedge clk);
    rst[1] = 1'b0;
    chk("rst_mid_no_ready", 32'(seen), 32'd0);
    chk("rst_mid_xcnt", xc[1], 32'd0);
    chk("rst_mid_fcnt", fc[1], 32'd0);
    ridx[1] = 4'd2; #1;
    chk("rst_mid_no_write", rsd[1], 32'd0);
    ridx[1] = 4'd0; #1;
    chk("rst_mid_res0", rsd[1], 32'd0);

    run_prog(1, 4, "rerun");
    chk("rerun_xcnt", xc[1], 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
